// File: rtl/fifo16_pkg.sv
// ---------------------------------------------------------------------------
// fifo16_pkg
// Shared definitions for the 16-entry distributed-RAM FIFO controllers
// (read side and write side).
//   FIFO16_DEPTH   RAM depth in entries
//   FIFO16_PTR_W   pointer width, bit 4 is the wrap bit
//   FIFO16_ADDR_W  RAM address width
//   FIFO16_HALF    threshold at which half_full asserts
//   fifo16_ptr_t   5-bit wrap pointer / occupancy
//   fifo16_level_t 5-bit total level, 0..17
//   fifo16_rd_state_t  read-side output stage state
// ---------------------------------------------------------------------------
package fifo16_pkg;

   localparam int unsigned FIFO16_DEPTH  = 16;
   localparam int unsigned FIFO16_PTR_W  = 5;
   localparam int unsigned FIFO16_ADDR_W = 4;
   localparam int unsigned FIFO16_HALF   = FIFO16_DEPTH / 2;

   typedef logic [FIFO16_PTR_W-1:0] fifo16_ptr_t;
   typedef logic [4:0]              fifo16_level_t;

   // Output register is either holding a valid head entry or not.
   typedef enum logic {
      RD_EMPTY   = 1'b0,
      RD_PRESENT = 1'b1
   } fifo16_rd_state_t;

endpackage

// File: rtl/fifo16_rd_port_if.sv
// ---------------------------------------------------------------------------
// fifo16_rd_port_if
// Consumer-side handshake of the FIFO read controller.
//   read          one-cycle strobe, consumes data_out
//   data_out      registered head entry
//   data_present  data_out holds a valid entry
//   level         entries held (RAM plus output register), 0..17
//   half_full     level >= 8
// Modports: slave = FIFO read controller, master = consumer.
// ---------------------------------------------------------------------------
interface fifo16_rd_port_if
   import fifo16_pkg::*;
#(
   parameter int unsigned DATA_W = 8
);

   logic              read;
   logic [DATA_W-1:0] data_out;
   logic              data_present;
   fifo16_level_t     level;
   logic              half_full;

   modport slave (
      input  read,
      output data_out,
      output data_present,
      output level,
      output half_full
   );

   modport master (
      output read,
      input  data_out,
      input  data_present,
      input  level,
      input  half_full
   );

endinterface

// File: rtl/fifo16_occ.sv
// ---------------------------------------------------------------------------
// fifo16_occ
// Combinational occupancy of the 16-entry RAM from the two wrap pointers.
// Shared by the read and write controllers.
//   wr_ptr  in   writer committed-write pointer
//   rd_ptr  in   reader pointer
//   occ     out  (wr_ptr - rd_ptr) mod 32, legal range 0..16
//   empty   out  occ == 0
//   full    out  occ == 16
// ---------------------------------------------------------------------------
module fifo16_occ
   import fifo16_pkg::*;
(
   input  fifo16_ptr_t wr_ptr,
   input  fifo16_ptr_t rd_ptr,
   output fifo16_ptr_t occ,
   output logic        empty,
   output logic        full
);

   always_comb begin
      occ   = wr_ptr - rd_ptr;
      empty = (occ == '0);
      full  = (occ == fifo16_ptr_t'(FIFO16_DEPTH));
   end

endmodule

// File: rtl/fifo16_rd_port.sv
// ---------------------------------------------------------------------------
// fifo16_rd_port
// Read-side controller for a 16-entry RAM16X1D_1 FIFO. Owns the read
// pointer, drives the RAM read address and prefetches the head entry into
// a registered output stage presented to the consumer.
//   clk      in   single clock (also the RAM WCLK)
//   reset    in   synchronous, active-high
//   wr_ptr   in   writer committed-write pointer
//   rd_ptr   out  read pointer, returned to the writer for full
//   rd_addr  out  rd_ptr[3:0], DPRA of every RAM slice
//   ram_dpo  in   concatenated DPO outputs (combinational read of rd_addr)
//   cons     consumer handshake (read/data_out/data_present/level/half_full)
//   underflow out sticky read-while-empty flag, only when
//            FIFO16_RD_UNDERFLOW_FLAG_EN is defined
// ---------------------------------------------------------------------------
module fifo16_rd_port
   import fifo16_pkg::*;
#(
   parameter int unsigned DATA_W = 8
)(
   input  logic                     clk,
   input  logic                     reset,
   input  fifo16_ptr_t              wr_ptr,
   output fifo16_ptr_t              rd_ptr,
   output logic [FIFO16_ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0]        ram_dpo,
   fifo16_rd_port_if.slave          cons
`ifdef FIFO16_RD_UNDERFLOW_FLAG_EN
   ,
   output logic                     underflow
`endif
);

   fifo16_rd_state_t  state_q, state_d;
   fifo16_ptr_t       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   fifo16_ptr_t       occ;
   logic              occ_empty;
   logic              occ_full;
   logic              load;

   fifo16_occ u_occ (
      .wr_ptr (wr_ptr),
      .rd_ptr (rd_ptr_q),
      .occ    (occ),
      .empty  (occ_empty),
      .full   (occ_full)
   );

   // Output stage: a load refills the register whenever RAM has data and
   // the register is free or being consumed this cycle.
   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
      load       = 1'b0;
      unique case (state_q)
         RD_EMPTY: begin
            if (!occ_empty) begin
               load    = 1'b1;
               state_d = RD_PRESENT;
            end
         end
         RD_PRESENT: begin
            if (cons.read) begin
               if (!occ_empty) begin
                  load = 1'b1;
               end else begin
                  state_d = RD_EMPTY;
               end
            end
         end
      endcase
      if (load) begin
         data_out_d = ram_dpo;
         rd_ptr_d   = rd_ptr_q + fifo16_ptr_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RD_EMPTY;
         rd_ptr_q   <= '0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         data_out_q <= data_out_d;
      end
   end

   // The writer never lets occupancy exceed the RAM depth, so any
   // occupancy with the wrap-distance bit set must be exactly full.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!occ[4] || occ_full);
      end
   end

`ifdef FIFO16_RD_UNDERFLOW_FLAG_EN
   logic underflow_q, underflow_d;

   always_comb begin
      underflow_d = underflow_q | (cons.read && (state_q == RD_EMPTY));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         underflow_q <= 1'b0;
      end else begin
         underflow_q <= underflow_d;
      end
   end

   always_comb begin
      underflow = underflow_q;
   end
`endif

   always_comb begin
      rd_ptr            = rd_ptr_q;
      rd_addr           = rd_ptr_q[FIFO16_ADDR_W-1:0];
      cons.data_out     = data_out_q;
      cons.data_present = (state_q == RD_PRESENT);
      cons.level        = fifo16_level_t'(occ)
                        + fifo16_level_t'(state_q == RD_PRESENT);
      cons.half_full    = (cons.level >= fifo16_level_t'(FIFO16_HALF));
   end

endmodule

// File: tb/tb_fifo16_rd_port.sv
module tb_fifo16_rd_port;
   import fifo16_pkg::*;

   localparam int unsigned DW = 8;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   fifo16_ptr_t wr_ptr = '0;
   fifo16_ptr_t rd_ptr;
   logic [3:0]  rd_addr;
   logic [DW-1:0] ram_dpo;
   logic [DW-1:0] mem [16];
`ifdef FIFO16_RD_UNDERFLOW_FLAG_EN
   logic underflow;
`endif

   fifo16_rd_port_if #(.DATA_W(DW)) cons_if ();

   fifo16_rd_port #(.DATA_W(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_ptr  (wr_ptr),
      .rd_ptr  (rd_ptr),
      .rd_addr (rd_addr),
      .ram_dpo (ram_dpo),
      .cons    (cons_if.slave)
`ifdef FIFO16_RD_UNDERFLOW_FLAG_EN
      ,
      .underflow (underflow)
`endif
   );

   always #5 clk = ~clk;

   always_comb ram_dpo = mem[rd_addr];

   int checks = 0;
   int errors = 0;

   // Reference model: RAM contents as a queue plus the output register.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q[$];
   bit            m_present = 0;
   logic [DW-1:0] m_dout = '0;
   int            m_rdcount = 0;
   bit            m_uf = 0;
   bit            started = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            mq.delete();
            m_present = 0;
            m_dout    = '0;
            m_rdcount = 0;
            m_uf      = 0;
            started   = 1;
         end else begin
            if (cons_if.read && !m_present) m_uf = 1;
            if (mq.size() != 0 && (!m_present || cons_if.read)) begin
               m_dout    = mq.pop_front();
               m_present = 1;
               m_rdcount = (m_rdcount + 1) % 32;
            end else if (cons_if.read && m_present) begin
               m_present = 0;
            end
         end
      end
   end

   // Monitor: state checks every cycle, scoreboard pop on each consumption.
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (started) begin
            chk("data_present", int'(cons_if.data_present), int'(m_present));
            chk("level", int'(cons_if.level), mq.size() + int'(m_present));
            chk("half_full", int'(cons_if.half_full), int'((mq.size() + int'(m_present)) >= 8));
            chk("rd_ptr", int'(rd_ptr), m_rdcount);
            chk("rd_addr", int'(rd_addr), m_rdcount % 16);
            chk("data_out_model", int'(cons_if.data_out), int'(m_dout));
`ifdef FIFO16_RD_UNDERFLOW_FLAG_EN
            chk("underflow", int'(underflow), int'(m_uf));
`endif
            if (cons_if.read && cons_if.data_present && !reset) begin
               if (exp_q.size() == 0) begin
                  chk("sb_unexpected_read", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_data", int'(cons_if.data_out), int'(e));
               end
            end
         end
      end
   end

   task automatic cyc(input bit wr, input logic [DW-1:0] d, input bit rd, input bit rst);
      @(posedge clk);
      #2;
      if (reset) begin
         wr_ptr = '0;
         exp_q.delete();
      end
      reset        = rst;
      cons_if.read = rd;
      if (wr && !rst && mq.size() < 16) begin
         mem[wr_ptr[3:0]] = d;
         wr_ptr           = wr_ptr + fifo16_ptr_t'(1);
         mq.push_back(d);
         exp_q.push_back(d);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      cons_if.read = 1'b0;

      // Reset state
      cyc(0, '0, 0, 1);
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("rst_data_present", int'(cons_if.data_present), 0);
      chk("rst_level", int'(cons_if.level), 0);
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_data_out", int'(cons_if.data_out), 0);

      // Fall-through latency of a single entry
      cyc(1, 8'hA5, 0, 0);
      @(negedge clk);
      chk("lat_not_yet", int'(cons_if.data_present), 0);
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("lat_present", int'(cons_if.data_present), 1);
      chk("lat_data", int'(cons_if.data_out), 8'hA5);
      chk("lat_rd_ptr", int'(rd_ptr), 1);
      chk("lat_level", int'(cons_if.level), 1);

      // Fill to 17 entries (16 in RAM + output register), then drain
      cyc(0, '0, 0, 1);
      cyc(0, '0, 0, 0);
      for (int i = 0; i < 17; i++) cyc(1, DW'(i), 0, 0);
      cyc(0, '0, 0, 0);
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("fill_level", int'(cons_if.level), 17);
      chk("fill_half_full", int'(cons_if.half_full), 1);
      chk("fill_rd_ptr", int'(rd_ptr), 1);
      chk("fill_head", int'(cons_if.data_out), 0);
      for (int i = 0; i < 17; i++) begin
         cyc(0, '0, 1, 0);
         @(negedge clk);
         chk("drain_order", int'(cons_if.data_out), i);
      end
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("drain_empty", int'(cons_if.data_present), 0);
      chk("drain_level", int'(cons_if.level), 0);

      // Wrap-around: write/read pairs
      for (int i = 0; i < 40; i++) begin
         cyc(1, DW'(i), i != 0, 0);
         @(negedge clk);
         chk("wrap_level_le2", int'(cons_if.level <= 2), 1);
      end
      cyc(0, '0, 1, 0);
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("wrap_rd_ptr", int'(rd_ptr), (17 + 40) % 32);

      // Read while empty
      cyc(0, '0, 0, 1);
      cyc(0, '0, 0, 0);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("empty_read_present", int'(cons_if.data_present), 0);
      chk("empty_read_rd_ptr", int'(rd_ptr), 0);
`ifdef FIFO16_RD_UNDERFLOW_FLAG_EN
      chk("underflow_set", int'(underflow), 1);
      for (int i = 0; i < 4; i++) cyc(1, DW'(i), 1, 0);
      @(negedge clk);
      chk("underflow_sticky", int'(underflow), 1);
`endif

      // Reset with level 9
      cyc(0, '0, 0, 1);
      cyc(0, '0, 0, 0);
      for (int i = 0; i < 9; i++) cyc(1, DW'(8'h30 + i), 0, 0);
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("pre_reset_level", int'(cons_if.level), 9);
      cyc(0, '0, 0, 1);
      cyc(0, '0, 0, 0);
      @(negedge clk);
      chk("post_reset_present", int'(cons_if.data_present), 0);
      chk("post_reset_rd_ptr", int'(rd_ptr), 0);
      chk("post_reset_level", int'(cons_if.level), 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 100) < 55, DW'($urandom), ($urandom % 100) < 50,
             ($urandom % 250) == 0);
      end
      cyc(0, '0, 0, 0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
